tap_controller: RTL and testbench
=================================

# tap_controller

IEEE 1149.1 TAP state machine for the JTAG core. It samples TMS on each rising TCK and walks the 16-state TAP graph. It drives the decoded stage strobes consumed by the instruction-register and data-register stages: TAP_RST, CAPTUREIR, SHIFTIR, UPDATEIR, and the DR equivalents. All strobes are registered so that downstream TCK gating is glitch-free.

## Interface
Parameters:
- none

Ports:
- TCK  input  1  JTAG test clock; the only clock.
- RST  input  1  Reset, synchronous and active-high; forces Test-Logic-Reset.
- TMS  input  1  Test mode select; sampled on posedge TCK.
- TAP_RST  output  1  Active-low TAP reset; 0 while in Test-Logic-Reset.
- CAPTUREIR / SHIFTIR / UPDATEIR  output  1 each  High while in Capture-IR / Shift-IR / Update-IR.
- CAPTUREDR / SHIFTDR / UPDATEDR  output  1 each  High while in Capture-DR / Shift-DR / Update-DR.
- RUNIDLE  output  1  High while in Run-Test/Idle.
- TDO_EN  output  1  High while in Shift-IR or Shift-DR; TDO output enable.
- STATE  output  4  Current state encoding. Present only with TAP_STATE_OUT_EN.

## Operation
State encoding is the standard 1149.1 encoding:
- TLR=F, RTI=C
- SELDR=7, CAPDR=6, SHDR=2, EX1DR=1, PSDR=3, EX2DR=0, UPDDR=5
- SELIR=4, CAPIR=E, SHIR=A, EX1IR=9, PSIR=B, EX2IR=8, UPDIR=D

Transitions (TMS=0 / TMS=1):
- TLR: RTI / TLR
- RTI: RTI / SELDR
- SELDR: CAPDR / SELIR
- CAPDR: SHDR / EX1DR
- SHDR: SHDR / EX1DR
- EX1DR: PSDR / UPDDR
- PSDR: PSDR / EX2DR
- EX2DR: SHDR / UPDDR
- UPDDR: RTI / SELDR
- SELIR: CAPIR / TLR
- IR states mirror the DR states.
- UPDIR: RTI / SELDR

Output and reset rules:
- Outputs are flops loaded from the decode of next_state, so each output equals decode(state) with no combinational path from TMS.
- RST=1 at a posedge TCK sets state=TLR. On the following cycle:
  - TAP_RST=0
  - all strobes, RUNIDLE and TDO_EN = 0
  - STATE=F
- RST has priority over TMS.
- TLR is reachable from any state in at most 5 TCKs with TMS=1, independent of RST.
- Illegal encodings cannot occur, since all 16 codes are used. The default branch still goes to TLR.

## Timing
- One-cycle latency: TMS sampled at posedge n produces the new state and its strobes valid from posedge n until posedge n+1.
- Each strobe is high for exactly one TCK per visit to a transient state (CAPxx, UPDxx). In SHxx, PSxx and RTI it stays high for as long as the state persists.
- Downstream stages register on posedge TCK while the strobe is high; e.g. the IR latch loads on the posedge that leaves UPDIR.
- RST asserted mid-shift aborts immediately: SHIFTIR/SHIFTDR drop and TDO_EN drops after that edge. No update strobe is issued.
- TAP_RST deasserts (goes to 1) one cycle after leaving TLR, i.e. with RUNIDLE rising.

## Configuration
- TAP_STATE_OUT_EN defined: STATE[3:0] port exists and mirrors the state register, for debug and bench observation.
- TAP_STATE_OUT_EN undefined: the port is absent and behaviour is otherwise identical.

## Structure
- Shared package jtag_pkg holds:
  - the 16 state localparams/typedef, 4-bit wide
  - the BYPASS instruction constant 4'hF
  - the IR width constant 4
- No sub-module: a single always block for state plus a registered decode. Next-state logic is a case statement.

## Test plan
- Reset: RST=1 for 1 TCK at any state -> STATE=F, TAP_RST=0, all strobes 0.
- TLR escape: from each of the 16 states (forced via RST plus a TMS path), TMS=1 for 5 TCKs -> STATE=F. Test-Logic-Reset is reached in ≤5 TCKs.
- IR scan, from RTI:
  - TMS sequence 1,1,0,0 -> SELDR, SELIR, CAPIR (CAPTUREIR=1 for exactly one cycle), SHIR.
  - 3 further TMS=0 -> SHIFTIR/TDO_EN high 4 cycles.
  - TMS=1,1 -> EX1IR, UPDIR (UPDATEIR=1 one cycle).
  - TMS=0 -> RTI, RUNIDLE=1.
- DR pause/resume: TMS 1,0,0,1,0,1,0,1,1 from RTI:
  - state path SELDR, CAPDR, SHDR, EX1DR, PSDR, EX2DR, SHDR, EX1DR, UPDDR
  - SHIFTDR high on both SHDR visits
  - UPDATEDR pulses once at the end
- Mid-operation reset: in SHDR, assert RST -> next cycle STATE=F and SHIFTDR=0, with no UPDATEDR pulse.
- Glitch check: randomize TMS for 10k cycles against a reference model. Compare outputs every cycle, and verify no output changes except at posedge TCK.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state encoding (IEEE 1149.1), IR constants,
// and the state-to-strobe decode used by the TAP controller.
package jtag_pkg;

    localparam int         IR_WIDTH     = 4;
    localparam logic [3:0] BYPASS_INSTR = 4'hF;

    typedef enum logic [3:0] {
        TLR   = 4'hF,
        RTI   = 4'hC,
        SELDR = 4'h7,
        CAPDR = 4'h6,
        SHDR  = 4'h2,
        EX1DR = 4'h1,
        PSDR  = 4'h3,
        EX2DR = 4'h0,
        UPDDR = 4'h5,
        SELIR = 4'h4,
        CAPIR = 4'hE,
        SHIR  = 4'hA,
        EX1IR = 4'h9,
        PSIR  = 4'hB,
        EX2IR = 4'h8,
        UPDIR = 4'hD
    } tap_state_t;

    typedef struct packed {
        logic tap_rst;
        logic capture_ir;
        logic shift_ir;
        logic update_ir;
        logic capture_dr;
        logic shift_dr;
        logic update_dr;
        logic run_idle;
        logic tdo_en;
    } tap_strobes_t;

    function automatic tap_strobes_t tap_decode(input tap_state_t s);
        tap_strobes_t d;
        d.tap_rst    = (s != TLR);
        d.capture_ir = (s == CAPIR);
        d.shift_ir   = (s == SHIR);
        d.update_ir  = (s == UPDIR);
        d.capture_dr = (s == CAPDR);
        d.shift_dr   = (s == SHDR);
        d.update_dr  = (s == UPDDR);
        d.run_idle   = (s == RTI);
        d.tdo_en     = (s == SHIR) || (s == SHDR);
        return d;
    endfunction

endpackage

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP state machine with registered stage strobes.
// Define TAP_STATE_OUT_EN to expose the state register on STATE[3:0].
module tap_controller
    import jtag_pkg::*;
(
    input  logic       TCK,
    input  logic       RST,
    input  logic       TMS,
    output logic       TAP_RST,
    output logic       CAPTUREIR,
    output logic       SHIFTIR,
    output logic       UPDATEIR,
    output logic       CAPTUREDR,
    output logic       SHIFTDR,
    output logic       UPDATEDR,
    output logic       RUNIDLE,
    output logic       TDO_EN
`ifdef TAP_STATE_OUT_EN
    ,
    output logic [3:0] STATE
`endif
);

    tap_state_t   state;
    tap_state_t   next_state;
    tap_strobes_t strobes;

    always_comb begin
        next_state = TLR;
        case (state)
            TLR:     next_state = TMS ? TLR   : RTI;
            RTI:     next_state = TMS ? SELDR : RTI;
            SELDR:   next_state = TMS ? SELIR : CAPDR;
            CAPDR:   next_state = TMS ? EX1DR : SHDR;
            SHDR:    next_state = TMS ? EX1DR : SHDR;
            EX1DR:   next_state = TMS ? UPDDR : PSDR;
            PSDR:    next_state = TMS ? EX2DR : PSDR;
            EX2DR:   next_state = TMS ? UPDDR : SHDR;
            UPDDR:   next_state = TMS ? SELDR : RTI;
            SELIR:   next_state = TMS ? TLR   : CAPIR;
            CAPIR:   next_state = TMS ? EX1IR : SHIR;
            SHIR:    next_state = TMS ? EX1IR : SHIR;
            EX1IR:   next_state = TMS ? UPDIR : PSIR;
            PSIR:    next_state = TMS ? EX2IR : PSIR;
            EX2IR:   next_state = TMS ? UPDIR : SHIR;
            UPDIR:   next_state = TMS ? SELDR : RTI;
            default: next_state = TLR;
        endcase
    end

    // Strobes are loaded from the decode of the incoming state so they are
    // plain flop outputs, aligned with the state register and free of TMS paths.
    always_ff @(posedge TCK) begin
        if (RST) begin
            state   <= TLR;
            strobes <= tap_decode(TLR);
        end else begin
            state   <= next_state;
            strobes <= tap_decode(next_state);
        end
    end

    assign TAP_RST   = strobes.tap_rst;
    assign CAPTUREIR = strobes.capture_ir;
    assign SHIFTIR   = strobes.shift_ir;
    assign UPDATEIR  = strobes.update_ir;
    assign CAPTUREDR = strobes.capture_dr;
    assign SHIFTDR   = strobes.shift_dr;
    assign UPDATEDR  = strobes.update_dr;
    assign RUNIDLE   = strobes.run_idle;
    assign TDO_EN    = strobes.tdo_en;

`ifdef TAP_STATE_OUT_EN
    assign STATE = state;
`endif

endmodule

// File: tb/tb_tap_controller.sv
// Self-checking bench for tap_controller: directed vector table, TLR escape
// from every state, and a long random TMS run against a transition-table model.
module tb_tap_controller;

    logic TCK = 1'b0;
    logic RST = 1'b1;
    logic TMS = 1'b1;
    logic TAP_RST, CAPTUREIR, SHIFTIR, UPDATEIR;
    logic CAPTUREDR, SHIFTDR, UPDATEDR, RUNIDLE, TDO_EN;
`ifdef TAP_STATE_OUT_EN
    logic [3:0] STATE;
`endif

    int checks = 0;
    int errors = 0;

    tap_controller dut (
        .TCK       (TCK),
        .RST       (RST),
        .TMS       (TMS),
        .TAP_RST   (TAP_RST),
        .CAPTUREIR (CAPTUREIR),
        .SHIFTIR   (SHIFTIR),
        .UPDATEIR  (UPDATEIR),
        .CAPTUREDR (CAPTUREDR),
        .SHIFTDR   (SHIFTDR),
        .UPDATEDR  (UPDATEDR),
        .RUNIDLE   (RUNIDLE),
        .TDO_EN    (TDO_EN)
`ifdef TAP_STATE_OUT_EN
        ,
        .STATE     (STATE)
`endif
    );

    always #5 TCK = ~TCK;

    // Output bundle order: TAP_RST, CAPTUREIR, SHIFTIR, UPDATEIR, CAPTUREDR,
    // SHIFTDR, UPDATEDR, RUNIDLE, TDO_EN.
    logic [8:0] act;
    assign act = {TAP_RST, CAPTUREIR, SHIFTIR, UPDATEIR, CAPTUREDR,
                  SHIFTDR, UPDATEDR, RUNIDLE, TDO_EN};

    localparam logic [8:0] O_TLR   = 9'b0_0000_0000;
    localparam logic [8:0] O_QUIET = 9'b1_0000_0000;
    localparam logic [8:0] O_RTI   = 9'b1_0000_0010;
    localparam logic [8:0] O_CAPIR = 9'b1_1000_0000;
    localparam logic [8:0] O_SHIR  = 9'b1_0100_0001;
    localparam logic [8:0] O_UPDIR = 9'b1_0010_0000;
    localparam logic [8:0] O_CAPDR = 9'b1_0001_0000;
    localparam logic [8:0] O_SHDR  = 9'b1_0000_1001;
    localparam logic [8:0] O_UPDDR = 9'b1_0000_0100;

    // Reference model: transition table written straight from the TAP graph.
    logic [3:0] next_tbl [16][2];
    logic [3:0] model_state;

    function automatic logic [8:0] model_out(input logic [3:0] s);
        logic [8:0] o;
        o = (s == 4'hF) ? O_TLR : O_QUIET;
        if (s == 4'hC) o = O_RTI;
        if (s == 4'hE) o = O_CAPIR;
        if (s == 4'hA) o = O_SHIR;
        if (s == 4'hD) o = O_UPDIR;
        if (s == 4'h6) o = O_CAPDR;
        if (s == 4'h2) o = O_SHDR;
        if (s == 4'h5) o = O_UPDDR;
        return o;
    endfunction

    task automatic checkOutput(input string name, input logic [8:0] exp_out,
                               input logic [3:0] exp_state);
        checks++;
        if (act !== exp_out) begin
            errors++;
            $display("[TB] FAIL %s: outputs got %b expected %b", name, act, exp_out);
        end
`ifdef TAP_STATE_OUT_EN
        checks++;
        if (STATE !== exp_state) begin
            errors++;
            $display("[TB] FAIL %s: STATE got %h expected %h", name, STATE, exp_state);
        end
`endif
    endtask

    // Drives one TCK of stimulus, advances the model, and samples 1 time unit
    // after the edge.
    task automatic applyStimulus(input logic rst, input logic tms);
        @(negedge TCK);
        RST = rst;
        TMS = tms;
        @(posedge TCK);
        model_state = rst ? 4'hF : next_tbl[model_state][tms];
        #1;
    endtask

    typedef struct {
        logic       rst;
        logic       tms;
        logic [8:0] exp_out;
        logic [3:0] exp_state;
        string      name;
    } vec_t;

    vec_t vecs[$];

    // Shortest TMS paths from TLR to every state, bit 0 applied first.
    typedef struct {
        logic [3:0] target;
        int         len;
        logic [7:0] path;
    } path_t;

    path_t paths[16];

    initial begin
        logic [8:0] prev;

        next_tbl[4'hF] = '{4'hC, 4'hF};
        next_tbl[4'hC] = '{4'hC, 4'h7};
        next_tbl[4'h7] = '{4'h6, 4'h4};
        next_tbl[4'h6] = '{4'h2, 4'h1};
        next_tbl[4'h2] = '{4'h2, 4'h1};
        next_tbl[4'h1] = '{4'h3, 4'h5};
        next_tbl[4'h3] = '{4'h3, 4'h0};
        next_tbl[4'h0] = '{4'h2, 4'h5};
        next_tbl[4'h5] = '{4'hC, 4'h7};
        next_tbl[4'h4] = '{4'hE, 4'hF};
        next_tbl[4'hE] = '{4'hA, 4'h9};
        next_tbl[4'hA] = '{4'hA, 4'h9};
        next_tbl[4'h9] = '{4'hB, 4'hD};
        next_tbl[4'hB] = '{4'hB, 4'h8};
        next_tbl[4'h8] = '{4'hA, 4'hD};
        next_tbl[4'hD] = '{4'hC, 4'h7};
        model_state = 4'hF;

        // Reset, IR scan from RTI, DR pause/resume, mid-shift reset.
        vecs.push_back('{1, 1, O_TLR,   4'hF, "reset"});
        vecs.push_back('{0, 0, O_RTI,   4'hC, "tlr_to_rti"});
        vecs.push_back('{0, 1, O_QUIET, 4'h7, "ir_seldr"});
        vecs.push_back('{0, 1, O_QUIET, 4'h4, "ir_selir"});
        vecs.push_back('{0, 0, O_CAPIR, 4'hE, "ir_capture"});
        vecs.push_back('{0, 0, O_SHIR,  4'hA, "ir_shift1"});
        vecs.push_back('{0, 0, O_SHIR,  4'hA, "ir_shift2"});
        vecs.push_back('{0, 0, O_SHIR,  4'hA, "ir_shift3"});
        vecs.push_back('{0, 0, O_SHIR,  4'hA, "ir_shift4"});
        vecs.push_back('{0, 1, O_QUIET, 4'h9, "ir_exit1"});
        vecs.push_back('{0, 1, O_UPDIR, 4'hD, "ir_update"});
        vecs.push_back('{0, 0, O_RTI,   4'hC, "ir_back_rti"});
        vecs.push_back('{0, 1, O_QUIET, 4'h7, "dr_seldr"});
        vecs.push_back('{0, 0, O_CAPDR, 4'h6, "dr_capture"});
        vecs.push_back('{0, 0, O_SHDR,  4'h2, "dr_shift_a"});
        vecs.push_back('{0, 1, O_QUIET, 4'h1, "dr_exit1_a"});
        vecs.push_back('{0, 0, O_QUIET, 4'h3, "dr_pause"});
        vecs.push_back('{0, 1, O_QUIET, 4'h0, "dr_exit2"});
        vecs.push_back('{0, 0, O_SHDR,  4'h2, "dr_shift_b"});
        vecs.push_back('{0, 1, O_QUIET, 4'h1, "dr_exit1_b"});
        vecs.push_back('{0, 1, O_UPDDR, 4'h5, "dr_update"});
        vecs.push_back('{0, 0, O_RTI,   4'hC, "dr_back_rti"});
        vecs.push_back('{0, 1, O_QUIET, 4'h7, "abort_seldr"});
        vecs.push_back('{0, 0, O_CAPDR, 4'h6, "abort_capdr"});
        vecs.push_back('{0, 0, O_SHDR,  4'h2, "abort_shdr"});
        vecs.push_back('{1, 1, O_TLR,   4'hF, "abort_reset"});
        vecs.push_back('{0, 1, O_TLR,   4'hF, "abort_hold_tlr"});
        vecs.push_back('{0, 0, O_RTI,   4'hC, "abort_rti"});
        vecs.push_back('{1, 0, O_TLR,   4'hF, "rst_beats_tms"});

        $display("[TB] directed vectors");
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].tms);
            checkOutput(vecs[i].name, vecs[i].exp_out, vecs[i].exp_state);
        end

        paths[0]  = '{4'hF, 0, 8'b0000_0000};
        paths[1]  = '{4'hC, 1, 8'b0000_0000};
        paths[2]  = '{4'h7, 2, 8'b0000_0010};
        paths[3]  = '{4'h6, 3, 8'b0000_0010};
        paths[4]  = '{4'h2, 4, 8'b0000_0010};
        paths[5]  = '{4'h1, 4, 8'b0000_1010};
        paths[6]  = '{4'h3, 5, 8'b0000_1010};
        paths[7]  = '{4'h0, 6, 8'b0010_1010};
        paths[8]  = '{4'h5, 5, 8'b0001_1010};
        paths[9]  = '{4'h4, 3, 8'b0000_0110};
        paths[10] = '{4'hE, 4, 8'b0000_0110};
        paths[11] = '{4'hA, 5, 8'b0000_0110};
        paths[12] = '{4'h9, 5, 8'b0001_0110};
        paths[13] = '{4'hB, 6, 8'b0001_0110};
        paths[14] = '{4'h8, 7, 8'b0101_0110};
        paths[15] = '{4'hD, 6, 8'b0011_0110};

        $display("[TB] TLR escape from every state");
        foreach (paths[p]) begin
            applyStimulus(1'b1, 1'b0);
            for (int k = 0; k < paths[p].len; k++)
                applyStimulus(1'b0, paths[p].path[k]);
            checkOutput($sformatf("reach_%h", paths[p].target),
                        model_out(paths[p].target), paths[p].target);
            for (int k = 0; k < 5; k++)
                applyStimulus(1'b0, 1'b1);
            checkOutput($sformatf("escape_from_%h", paths[p].target), O_TLR, 4'hF);
        end

        $display("[TB] random TMS against model");
        applyStimulus(1'b1, 1'b1);
        prev = act;
        for (int n = 0; n < 10000; n++) begin
            logic r, t;
            r = ($urandom_range(0, 63) == 0);
            t = 1'($urandom);
            @(negedge TCK);
            RST = r;
            TMS = t;
            #1;
            checks++;
            if (act !== prev) begin
                errors++;
                $display("[TB] FAIL glitch_%0d: outputs got %b expected %b", n, act, prev);
            end
            @(posedge TCK);
            model_state = r ? 4'hF : next_tbl[model_state][t];
            #1;
            checkOutput($sformatf("random_%0d", n), model_out(model_state), model_state);
            prev = act;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
